// File: rtl/cpu_test_harness_pkg.sv
// ----------------------------------------------------------------------------
// cpu_harness_pkg
//  Shared definitions for the CPU boot/run harness: controller state
//  encoding and the load-stream target select values.
// ----------------------------------------------------------------------------
package cpu_harness_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR_RF,
        LOAD,
        RUN,
        DONE,
        TIMEOUT
    } state_t;

    localparam logic LD_SEL_IM = 1'b0;
    localparam logic LD_SEL_DM = 1'b1;

endpackage

// File: rtl/cpu_test_harness_if.sv
// ----------------------------------------------------------------------------
// cpu_test_harness_if
//  Load stream from the host into the harness (program/data words).
//  master : host side, drives the word and its qualifiers
//  slave  : harness side, returns ld_ready
//  Signals: ld_valid, ld_ready, ld_sel (0 = IM, 1 = DM), ld_addr, ld_data,
//           ld_last (final word of the image)
// ----------------------------------------------------------------------------
interface cpu_test_harness_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_sel;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;

    modport master (
        output ld_valid, ld_sel, ld_addr, ld_data, ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid, ld_sel, ld_addr, ld_data, ld_last,
        output ld_ready
    );
endinterface

// File: rtl/cpu_test_harness.sv
// ----------------------------------------------------------------------------
// cpu_test_harness
//  Boot/run controller wrapped around the CPU: clears the register file,
//  streams a program into IM and data into DM, releases the CPU reset, then
//  counts run cycles until the CPU reaches halt_pc or the watchdog expires.
//
//  Ports
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a sequence (honoured in IDLE/DONE/TIMEOUT)
//   timeout_limit         max RUN cycles, 0 disables the watchdog
//   halt_pc               PC value that ends the run
//   ld                    load stream (slave side)
//   cpu_pc                current CPU PC
//   cpu_rst               CPU reset, low only while running
//   rf_* / im_* / dm_*    regfile / IM / DM write ports
//   busy, done, timeout   status
//   cycle_count           RUN cycles of the current/last run
//
//  state   | meaning
//  --------+----------------------------------------------------
//  IDLE    | waiting for start, CPU held in reset
//  CLR_RF  | writing zero to rf_addr 0..RF_DEPTH-1, one per cycle
//  LOAD    | accepting load words into IM/DM until ld_last
//  RUN     | CPU released, counting cycles, watching PC/watchdog
//  DONE    | halt PC reached, CPU frozen
//  TIMEOUT | watchdog expired, CPU frozen
// ----------------------------------------------------------------------------
module cpu_test_harness
    import cpu_harness_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int ADDR_W   = 10,
    parameter  int RF_DEPTH = 32,
    parameter  int PC_W     = 32,
    parameter  int CNT_W    = 32,
    localparam int RF_AW    = $clog2(RF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  timeout_limit,
    input  logic [PC_W-1:0]   halt_pc,
    cpu_test_harness_if.slave ld,
    input  logic [PC_W-1:0]   cpu_pc,
    output logic              cpu_rst,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam logic [RF_AW-1:0] RF_LAST = RF_AW'(RF_DEPTH - 1);

    state_t             state, state_nxt;
    logic               ld_fire;
    logic               cpu_rst_nxt, busy_nxt, done_nxt, timeout_nxt;
    logic               rf_we_nxt, im_we_nxt, dm_we_nxt;
    logic [RF_AW-1:0]   rf_addr_nxt;
    logic [ADDR_W-1:0]  im_addr_nxt, dm_addr_nxt;
    logic [DATA_W-1:0]  im_wdata_nxt, dm_wdata_nxt;
    logic [CNT_W-1:0]   cycle_count_nxt;

    assign ld.ld_ready = (state == LOAD);
    assign ld_fire     = ld.ld_valid & ld.ld_ready;
    assign rf_wdata    = '0;

    always_comb begin
        state_nxt       = state;
        rf_we_nxt       = 1'b0;
        rf_addr_nxt     = rf_addr;
        im_we_nxt       = 1'b0;
        im_addr_nxt     = im_addr;
        im_wdata_nxt    = im_wdata;
        dm_we_nxt       = 1'b0;
        dm_addr_nxt     = dm_addr;
        dm_wdata_nxt    = dm_wdata;
        done_nxt        = done;
        timeout_nxt     = timeout;
        cycle_count_nxt = cycle_count;

        case (state)
            IDLE, DONE, TIMEOUT: begin
                if (start) begin
                    state_nxt       = CLR_RF;
                    rf_we_nxt       = 1'b1;
                    rf_addr_nxt     = '0;
                    done_nxt        = 1'b0;
                    timeout_nxt     = 1'b0;
                    cycle_count_nxt = '0;
                end
            end
            CLR_RF: begin
                // rf_we is already high for the current address; stop after the last one
                if (rf_addr == RF_LAST) begin
                    state_nxt = LOAD;
                end else begin
                    rf_we_nxt   = 1'b1;
                    rf_addr_nxt = rf_addr + 1'b1;
                end
            end
            LOAD: begin
                if (ld_fire) begin
                    if (ld.ld_sel == LD_SEL_DM) begin
                        dm_we_nxt    = 1'b1;
                        dm_addr_nxt  = ld.ld_addr;
                        dm_wdata_nxt = ld.ld_data;
                    end else begin
                        im_we_nxt    = 1'b1;
                        im_addr_nxt  = ld.ld_addr;
                        im_wdata_nxt = ld.ld_data;
                    end
                    if (ld.ld_last) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (cycle_count != '1) begin
                    cycle_count_nxt = cycle_count + 1'b1;
                end
                // halt takes priority over a watchdog expiring in the same cycle
                if (cpu_pc == halt_pc) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else if (timeout_limit != '0 &&
                             cycle_count == timeout_limit - CNT_W'(1)) begin
                    state_nxt   = TIMEOUT;
                    timeout_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        cpu_rst_nxt = (state_nxt != RUN);
        busy_nxt    = (state_nxt == CLR_RF) || (state_nxt == LOAD) || (state_nxt == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cpu_rst     <= 1'b1;
            rf_we       <= 1'b0;
            rf_addr     <= '0;
            im_we       <= 1'b0;
            im_addr     <= '0;
            im_wdata    <= '0;
            dm_we       <= 1'b0;
            dm_addr     <= '0;
            dm_wdata    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_nxt;
            cpu_rst     <= cpu_rst_nxt;
            rf_we       <= rf_we_nxt;
            rf_addr     <= rf_addr_nxt;
            im_we       <= im_we_nxt;
            im_addr     <= im_addr_nxt;
            im_wdata    <= im_wdata_nxt;
            dm_we       <= dm_we_nxt;
            dm_addr     <= dm_addr_nxt;
            dm_wdata    <= dm_wdata_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            timeout     <= timeout_nxt;
            cycle_count <= cycle_count_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_test_harness.sv
// ----------------------------------------------------------------------------
// tb_cpu_test_harness
//  Directed bench for cpu_test_harness with a stand-in CPU whose PC advances
//  by 4 every cycle it is out of reset.
// ----------------------------------------------------------------------------
module tb_cpu_test_harness;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int RF_AW  = 5;

    localparam int P_IDLE = 0;
    localparam int P_CLR  = 1;
    localparam int P_LOAD = 2;
    localparam int P_RUN  = 3;
    localparam int P_DONE = 4;
    localparam int P_TO   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [31:0]       timeout_limit;
    logic [31:0]       halt_pc;
    logic [31:0]       cpu_pc;
    logic              cpu_rst;
    logic              rf_we;
    logic [RF_AW-1:0]  rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              im_we, dm_we;
    logic [ADDR_W-1:0] im_addr, dm_addr;
    logic [DATA_W-1:0] im_wdata, dm_wdata;
    logic              busy, done, timeout;
    logic [31:0]       cycle_count;

    cpu_test_harness_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ld_bus ();

    cpu_test_harness dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .timeout_limit (timeout_limit),
        .halt_pc       (halt_pc),
        .ld            (ld_bus),
        .cpu_pc        (cpu_pc),
        .cpu_rst       (cpu_rst),
        .rf_we         (rf_we),
        .rf_addr       (rf_addr),
        .rf_wdata      (rf_wdata),
        .im_we         (im_we),
        .im_addr       (im_addr),
        .im_wdata      (im_wdata),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    // stand-in CPU: PC restarts at 0 while held, otherwise steps one word per cycle
    always @(posedge clk) begin
        if (cpu_rst !== 1'b0) cpu_pc <= 32'h0;
        else                  cpu_pc <= cpu_pc + 32'd4;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_ok = 1'b0;
    int          ph;
    int          clr_n;
    logic        m_imwe, m_dmwe;
    logic [ADDR_W-1:0] m_imaddr, m_dmaddr;
    logic [DATA_W-1:0] m_imdata, m_dmdata;
    logic        m_done, m_to;
    logic [31:0] m_cnt;

    always @(posedge clk) begin
        m_imwe <= 1'b0;
        m_dmwe <= 1'b0;
        if (rst) begin
            m_ok   <= 1'b1;
            ph     <= P_IDLE;
            clr_n  <= 0;
            m_done <= 1'b0;
            m_to   <= 1'b0;
            m_cnt  <= 32'h0;
        end else begin
            case (ph)
                P_IDLE, P_DONE, P_TO: if (start) begin
                    ph     <= P_CLR;
                    clr_n  <= 0;
                    m_done <= 1'b0;
                    m_to   <= 1'b0;
                    m_cnt  <= 32'h0;
                end
                P_CLR: begin
                    clr_n <= clr_n + 1;
                    if (clr_n == 31) ph <= P_LOAD;
                end
                P_LOAD: if (ld_bus.ld_valid) begin
                    if (ld_bus.ld_sel) begin
                        m_dmwe <= 1'b1; m_dmaddr <= ld_bus.ld_addr; m_dmdata <= ld_bus.ld_data;
                    end else begin
                        m_imwe <= 1'b1; m_imaddr <= ld_bus.ld_addr; m_imdata <= ld_bus.ld_data;
                    end
                    if (ld_bus.ld_last) ph <= P_RUN;
                end
                P_RUN: begin
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
                    if (cpu_pc == halt_pc) begin
                        ph <= P_DONE; m_done <= 1'b1;
                    end else if (timeout_limit != 0 && 64'(m_cnt) + 64'd1 == 64'(timeout_limit)) begin
                        ph <= P_TO; m_to <= 1'b1;
                    end
                end
                default: ph <= P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cpu_rst",  cpu_rst,        ph != P_RUN);
            chk("ld_ready", ld_bus.ld_ready, ph == P_LOAD);
            chk("busy",     busy,           ph == P_CLR || ph == P_LOAD || ph == P_RUN);
            chk("rf_we",    rf_we,          ph == P_CLR);
            if (ph == P_CLR) begin
                chk("rf_addr",  64'(rf_addr),  64'(clr_n));
                chk("rf_wdata", 64'(rf_wdata), 64'h0);
            end
            chk("im_we", im_we, m_imwe);
            if (m_imwe) begin
                chk("im_addr",  64'(im_addr),  64'(m_imaddr));
                chk("im_wdata", 64'(im_wdata), 64'(m_imdata));
            end
            chk("dm_we", dm_we, m_dmwe);
            if (m_dmwe) begin
                chk("dm_addr",  64'(dm_addr),  64'(m_dmaddr));
                chk("dm_wdata", 64'(dm_wdata), 64'(m_dmdata));
            end
            chk("done",        done,              m_done);
            chk("timeout",     timeout,           m_to);
            chk("cycle_count", 64'(cycle_count),  64'(m_cnt));
        end
    end

    // ---------------- write observers ----------------
    logic [ADDR_W+DATA_W-1:0] obs_im[$];
    logic [ADDR_W+DATA_W-1:0] obs_dm[$];
    int rf_seen;

    always @(negedge clk) begin
        if (im_we === 1'b1) obs_im.push_back({im_addr, im_wdata});
        if (dm_we === 1'b1) obs_dm.push_back({dm_addr, dm_wdata});
        if (rf_we === 1'b1) rf_seen++;
    end

    // ---------------- stimulus ----------------
    logic [31:0] im_prog[12];

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // called at a negedge; returns at a negedge
    task automatic send_word(input logic sel, input int addr, input logic [31:0] data,
                             input logic last, input int gap);
        int n;
        ld_bus.ld_valid = 1'b1;
        ld_bus.ld_sel   = sel;
        ld_bus.ld_addr  = ADDR_W'(addr);
        ld_bus.ld_data  = data;
        ld_bus.ld_last  = last;
        n = 0;
        while (ld_bus.ld_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ld_ready_wait", 64'(n), 64'd0);
        @(negedge clk);
        ld_bus.ld_valid = 1'b0;
        ld_bus.ld_last  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // first RUN cycle is the current one; counts cycles until a flag shows
    task automatic wait_end(output int run_n, input bit poke_start);
        int n;
        run_n = 1;
        n = 0;
        while (!(done === 1'b1 || timeout === 1'b1) && n < 2000) begin
            if (poke_start && n == 5) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n++;
            if (!(done === 1'b1 || timeout === 1'b1)) run_n++;
        end
        if (n >= 2000) chk("run_wait", 64'(n), 64'd0);
    endtask

    initial begin
        int run_n;
        rst = 1'b1; start = 1'b0;
        timeout_limit = 32'd1000; halt_pc = 32'h2C;
        ld_bus.ld_valid = 1'b0; ld_bus.ld_sel = 1'b0; ld_bus.ld_addr = '0;
        ld_bus.ld_data = '0; ld_bus.ld_last = 1'b0;
        for (int i = 0; i < 11; i++) im_prog[i] = 32'h2108_0001 + 32'(i);
        im_prog[11] = 32'h0800_0000;

        // 1: reset
        repeat (3) @(negedge clk);
        chk("rst_cpu_rst",  cpu_rst, 1'b1);
        chk("rst_rf_we",    rf_we, 1'b0);
        chk("rst_im_we",    im_we, 1'b0);
        chk("rst_dm_we",    dm_we, 1'b0);
        chk("rst_ld_ready", ld_bus.ld_ready, 1'b0);
        chk("rst_done",     done, 1'b0);
        chk("rst_timeout",  timeout, 1'b0);
        chk("rst_count",    64'(cycle_count), 64'd0);
        rst = 1'b0;

        // 2-4: clear, program + data load, run to halt (start poked mid-run)
        rf_seen = 0;
        do_start();
        chk("clr_first_we",   rf_we, 1'b1);
        chk("clr_first_addr", 64'(rf_addr), 64'd0);
        for (int i = 0; i < 12; i++) send_word(1'b0, i, im_prog[i], 1'b0, 2);
        for (int i = 0; i < 8; i++)  send_word(1'b1, i, 32'(i), i == 7, (i == 7) ? 0 : 2);
        chk("run_cpu_rst_low", cpu_rst, 1'b0);
        wait_end(run_n, 1'b1);
        chk("rf_write_count", 64'(rf_seen), 64'd32);
        chk("im_write_count", 64'(obs_im.size()), 64'd12);
        chk("dm_write_count", 64'(obs_dm.size()), 64'd8);
        for (int i = 0; i < 12 && i < obs_im.size(); i++)
            chk("im_seq", 64'(obs_im[i]), 64'({ADDR_W'(i), im_prog[i]}));
        for (int i = 0; i < 8 && i < obs_dm.size(); i++)
            chk("dm_seq", 64'(obs_dm[i]), 64'({ADDR_W'(i), 32'(i)}));
        chk("halt_done",     done, 1'b1);
        chk("halt_timeout",  timeout, 1'b0);
        chk("halt_count",    64'(cycle_count), 64'd12);
        chk("halt_count_tb", 64'(cycle_count), 64'(run_n));
        chk("halt_cpu_rst",  cpu_rst, 1'b1);

        // 5: watchdog
        timeout_limit = 32'd5; halt_pc = 32'hFFFF_FFF0;
        do_start();
        send_word(1'b0, 0, im_prog[0], 1'b1, 0);
        wait_end(run_n, 1'b0);
        chk("wd_timeout",  timeout, 1'b1);
        chk("wd_done",     done, 1'b0);
        chk("wd_count",    64'(cycle_count), 64'd5);
        chk("wd_count_tb", 64'(run_n), 64'd5);

        // 6a: reset in the middle of a load, then restart
        do_start();
        for (int i = 0; i < 4; i++) send_word(1'b0, i, im_prog[i], 1'b0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ld_ready", ld_bus.ld_ready, 1'b0);
        chk("midrst_busy",     busy, 1'b0);
        chk("midrst_cpu_rst",  cpu_rst, 1'b1);
        chk("midrst_timeout",  timeout, 1'b0);
        timeout_limit = 32'd3; halt_pc = 32'h8;
        rf_seen = 0;
        do_start();
        chk("restart_rf_we",   rf_we, 1'b1);
        chk("restart_rf_addr", 64'(rf_addr), 64'd0);

        // 6b: halt on the same cycle the watchdog expires
        send_word(1'b1, 3, 32'hDEAD_BEEF, 1'b1, 0);
        chk("restart_rf_count", 64'(rf_seen), 64'd32);
        wait_end(run_n, 1'b0);
        chk("tie_done",    done, 1'b1);
        chk("tie_timeout", timeout, 1'b0);
        chk("tie_count",   64'(cycle_count), 64'd3);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
